// File: rtl/csr_core.sv
// Control/status register file: trap entry/return, interrupt pending logic, LL/SC bit.
// Optional timer (TCFG/TVAL/TICLR, IS[11]) is built only when CSR_TIMER_EN is defined.
module csr_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_is_exception_i,
  input  logic [31:0] csr_exception_pc_i,
  input  logic [31:0] csr_exception_addr_i,
  input  logic [5:0]  csr_ecode_i,
  input  logic [8:0]  csr_esubcode_i,
  input  logic        is_ertn_i,
  input  logic        csr_write_en_i,
  input  logic [13:0] csr_write_addr_i,
  input  logic [31:0] csr_write_data_i,
  input  logic        is_llw_scw_i,
  input  logic        llbit_value_i,
  input  logic [13:0] csr_read_addr_i,
  input  logic [7:0]  hw_int_i,
  output logic [31:0] csr_read_data_o,
  output logic [31:0] csr_eentry_o,
  output logic [31:0] csr_era_o,
  output logic [31:0] csr_crmd_o,
  output logic        csr_is_interrupt_o,
  output logic        llbit_o
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_SAVE1  = 14'h031;
  localparam logic [13:0] ADDR_SAVE2  = 14'h032;
  localparam logic [13:0] ADDR_SAVE3  = 14'h033;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_LLBCTL = 14'h060;
  localparam logic [12:0] LIE_MASK    = 13'h1BFF;

  logic [1:0]  crmd_plv;
  logic        crmd_ie, crmd_da, crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era, badv, save0, save1, save2, save3, tid;
  logic [25:0] eentry_va;
  logic        llb_rollb, llb_klo;

  logic [12:0] is_all;
  logic [31:0] crmd_value, estat_value;
  logic        badv_from_pc, badv_from_addr;

  function automatic logic wr_hit(input logic [13:0] a);
    return csr_write_en_i && (csr_write_addr_i == a);
  endfunction

  assign is_all      = {1'b0, is_timer, 1'b0, is_hw, is_sw};
  assign crmd_value  = {27'd0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
  assign estat_value = {1'b0, estat_esubcode, estat_ecode, 3'd0, is_all};

  // ADEF records the fetch PC; ALE-with-subcode / ADEM record the data address.
  assign badv_from_pc   = (csr_ecode_i == 6'h08) && (csr_esubcode_i == 9'd0);
  assign badv_from_addr = ((csr_ecode_i == 6'h08) && (csr_esubcode_i == 9'd1)) ||
                          (csr_ecode_i == 6'h09);

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_plv       <= 2'd0;
      crmd_ie        <= 1'b0;
      crmd_da        <= 1'b1;
      crmd_pg        <= 1'b0;
      prmd_pplv      <= 2'd0;
      prmd_pie       <= 1'b0;
      ecfg_lie       <= 13'd0;
      is_sw          <= 2'd0;
      is_hw          <= 8'd0;
      estat_ecode    <= 6'd0;
      estat_esubcode <= 9'd0;
      era            <= 32'd0;
      badv           <= 32'd0;
      eentry_va      <= 26'd0;
      save0          <= 32'd0;
      save1          <= 32'd0;
      save2          <= 32'd0;
      save3          <= 32'd0;
      tid            <= 32'd0;
      llb_rollb      <= 1'b0;
      llb_klo        <= 1'b0;
    end else begin
      // Each field takes its highest-priority source; untouched fields keep lower ones.
      if (csr_is_exception_i) begin
        crmd_plv <= 2'd0;
        crmd_ie  <= 1'b0;
      end else if (is_ertn_i) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr_hit(ADDR_CRMD)) begin
        crmd_plv <= csr_write_data_i[1:0];
        crmd_ie  <= csr_write_data_i[2];
      end
      if (wr_hit(ADDR_CRMD)) begin
        crmd_da <= csr_write_data_i[3];
        crmd_pg <= csr_write_data_i[4];
      end

      if (csr_is_exception_i) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
      end else if (wr_hit(ADDR_PRMD)) begin
        prmd_pplv <= csr_write_data_i[1:0];
        prmd_pie  <= csr_write_data_i[2];
      end

      if (csr_is_exception_i) era <= csr_exception_pc_i;
      else if (wr_hit(ADDR_ERA)) era <= csr_write_data_i;

      if (csr_is_exception_i && badv_from_pc) badv <= csr_exception_pc_i;
      else if (csr_is_exception_i && badv_from_addr) badv <= csr_exception_addr_i;
      else if (wr_hit(ADDR_BADV)) badv <= csr_write_data_i;

      if (csr_is_exception_i) begin
        estat_ecode    <= csr_ecode_i;
        estat_esubcode <= csr_esubcode_i;
      end
      if (wr_hit(ADDR_ESTAT)) is_sw <= csr_write_data_i[1:0];
      is_hw <= hw_int_i;

      if (wr_hit(ADDR_ECFG))   ecfg_lie  <= csr_write_data_i[12:0] & LIE_MASK;
      if (wr_hit(ADDR_EENTRY)) eentry_va <= csr_write_data_i[31:6];
      if (wr_hit(ADDR_SAVE0))  save0     <= csr_write_data_i;
      if (wr_hit(ADDR_SAVE1))  save1     <= csr_write_data_i;
      if (wr_hit(ADDR_SAVE2))  save2     <= csr_write_data_i;
      if (wr_hit(ADDR_SAVE3))  save3     <= csr_write_data_i;
      if (wr_hit(ADDR_TID))    tid       <= csr_write_data_i;

      if (is_ertn_i) llb_klo <= 1'b0;
      else if (wr_hit(ADDR_LLBCTL)) llb_klo <= csr_write_data_i[2];

      if (is_ertn_i && !llb_klo) llb_rollb <= 1'b0;
      else if (is_llw_scw_i) llb_rollb <= llbit_value_i;
    end
  end

`ifdef CSR_TIMER_EN
  localparam logic [13:0] ADDR_TCFG  = 14'h041;
  localparam logic [13:0] ADDR_TVAL  = 14'h042;
  localparam logic [13:0] ADDR_TICLR = 14'h044;

  logic        tcfg_en, tcfg_periodic;
  logic [29:0] tcfg_initval;
  logic [31:0] tval;
  logic        timer_fire;

  // A TCFG write restarts the countdown, so it suppresses this cycle's expiry.
  assign timer_fire = !wr_hit(ADDR_TCFG) && tcfg_en && (tval == 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg_en       <= 1'b0;
      tcfg_periodic <= 1'b0;
      tcfg_initval  <= 30'd0;
      tval          <= 32'd0;
      is_timer      <= 1'b0;
    end else begin
      if (wr_hit(ADDR_TCFG)) begin
        tcfg_en       <= csr_write_data_i[0];
        tcfg_periodic <= csr_write_data_i[1];
        tcfg_initval  <= csr_write_data_i[31:2];
        tval          <= {csr_write_data_i[31:2], 2'b00};
      end else if (tcfg_en) begin
        if (tval == 32'd1) begin
          tval <= 32'd0;
          if (!tcfg_periodic) tcfg_en <= 1'b0;
        end else if (tval != 32'd0) begin
          tval <= tval - 32'd1;
        end else if (tcfg_periodic) begin
          tval <= {tcfg_initval, 2'b00};
        end
      end

      if (timer_fire) is_timer <= 1'b1;
      else if (wr_hit(ADDR_TICLR) && csr_write_data_i[0]) is_timer <= 1'b0;
    end
  end
`else
  assign is_timer = 1'b0;
`endif

  always_comb begin
    csr_read_data_o = 32'd0;
    case (csr_read_addr_i)
      ADDR_CRMD:   csr_read_data_o = crmd_value;
      ADDR_PRMD:   csr_read_data_o = {29'd0, prmd_pie, prmd_pplv};
      ADDR_ECFG:   csr_read_data_o = {19'd0, ecfg_lie};
      ADDR_ESTAT:  csr_read_data_o = estat_value;
      ADDR_ERA:    csr_read_data_o = era;
      ADDR_BADV:   csr_read_data_o = badv;
      ADDR_EENTRY: csr_read_data_o = {eentry_va, 6'd0};
      ADDR_SAVE0:  csr_read_data_o = save0;
      ADDR_SAVE1:  csr_read_data_o = save1;
      ADDR_SAVE2:  csr_read_data_o = save2;
      ADDR_SAVE3:  csr_read_data_o = save3;
      ADDR_TID:    csr_read_data_o = tid;
      ADDR_LLBCTL: csr_read_data_o = {29'd0, llb_klo, 1'b0, llb_rollb};
`ifdef CSR_TIMER_EN
      ADDR_TCFG:   csr_read_data_o = {tcfg_initval, tcfg_periodic, tcfg_en};
      ADDR_TVAL:   csr_read_data_o = tval;
`endif
      default:     csr_read_data_o = 32'd0;
    endcase
  end

  assign csr_eentry_o       = {eentry_va, 6'd0};
  assign csr_era_o          = era;
  assign csr_crmd_o         = crmd_value;
  assign csr_is_interrupt_o = crmd_ie & (|(is_all & ecfg_lie));
  assign llbit_o            = llb_rollb;

endmodule

// File: doc/csr_core.md
CSR_CORE -- requirements
Module: csr_core

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have these exception/return inputs from the commit controller: csr_is_exception_i in 1 trap commit; csr_exception_pc_i in 32 faulting PC; csr_exception_addr_i in 32 faulting memory address; csr_ecode_i in 6; csr_esubcode_i in 9; is_ertn_i in 1 exception return.
REQ-003 SHALL have these CSR write and LL/SC inputs: csr_write_en_i in 1; csr_write_addr_i in 14; csr_write_data_i in 32; is_llw_scw_i in 1 LL/SC commit; llbit_value_i in 1 new LLbit.
REQ-004 SHALL have these read-port and interrupt inputs: csr_read_addr_i in 14; hw_int_i in 8 external interrupt lines.
REQ-005 SHALL have these outputs: csr_read_data_o out 32; csr_eentry_o out 32; csr_era_o out 32; csr_crmd_o out 32; csr_is_interrupt_o out 1; llbit_o out 1.

Function
REQ-006 SHALL implement these registers and addresses: CRMD 0x0 (PLV[1:0], IE[2], DA[3], PG[4]); PRMD 0x1 (PPLV[1:0], PIE[2]); ECFG 0x4 (LIE[12:0], bit10 reads 0); ESTAT 0x5 (IS[12:0], Ecode[21:16], EsubCode[30:22]); ERA 0x6; BADV 0x7; EENTRY 0xC ([31:6], [5:0] read 0); SAVE0-3 0x30-0x33; TID 0x40; LLBCTL 0x60 (ROLLB[0] read-only, KLO[2]).
REQ-007 SHALL return combinationally the current registered value on csr_read_data_o, with no write bypass; unimplemented addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-008 SHALL apply a CSR write at the clock edge, masked to writable fields only; only IS[1:0] of ESTAT SHALL be software-writable.
REQ-009 SHALL, on csr_is_exception_i: set PRMD.PPLV/PIE to CRMD.PLV/IE; set CRMD.PLV to 0 and CRMD.IE to 0; set ERA to csr_exception_pc_i; set ESTAT.Ecode/EsubCode to csr_ecode_i/csr_esubcode_i.
REQ-010 SHALL, on an exception, update BADV as follows: ecode 0x8 with esubcode 0 (ADEF) writes csr_exception_pc_i; ecode 0x8 with esubcode 1, or ecode 0x9, writes csr_exception_addr_i; any other ecode leaves BADV unchanged.
REQ-011 SHALL, on is_ertn_i: restore CRMD.PLV/IE from PRMD.PPLV/PIE; clear LLBCTL.ROLLB when KLO=0; clear KLO.
REQ-012 SHALL, when more than one event occurs in the same cycle, apply them with priority exception > ertn > CSR write > is_llw_scw_i; a lower-priority event SHALL be dropped only for fields the higher one updates.
REQ-013 SHALL, on is_llw_scw_i, set ROLLB to llbit_value_i; llbit_o SHALL equal ROLLB.
REQ-014 SHALL sample hw_int_i into ESTAT.IS[9:2] every cycle, giving one cycle of latency.
REQ-015 SHALL drive csr_is_interrupt_o as the registered-state combinational function CRMD.IE AND OR(IS[12:0] AND LIE[12:0]).
REQ-016 SHALL drive csr_eentry_o, csr_era_o and csr_crmd_o directly from the registers.

Reset
REQ-017 SHALL, with rst high at the clock edge, reset CRMD to 0x00000008 (DA=1); all other registers, IS included, SHALL reset to 0.
REQ-018 SHALL have all outputs equal to 0 in the cycle after reset, except csr_crmd_o=0x8 and csr_read_data_o, which follows its address.
REQ-019 SHALL give rst priority over every simultaneous event; an in-progress timer countdown SHALL be aborted by reset.

Configuration
REQ-020 SHALL, with macro CSR_TIMER_EN defined, add TCFG 0x41 (En[0], Periodic[1], InitVal[31:2]), TVAL 0x42 (read-only) and TICLR 0x44 (write-only, reads 0).
REQ-021 SHALL, on a TCFG write, load TVAL with {InitVal,2'b00}.
REQ-022 SHALL, while En=1 and TVAL!=0, decrement TVAL by 1 per cycle.
REQ-023 SHALL, on the 1->0 transition of TVAL, set IS[11]; if Periodic, TVAL SHALL reload {InitVal,00} on the next cycle, otherwise En SHALL clear and TVAL SHALL hold 0.
REQ-024 SHALL clear IS[11] when TICLR is written with bit0=1; if a timer set and a TICLR clear occur in the same cycle, the set SHALL win.
REQ-025 SHALL, without CSR_TIMER_EN, read addresses 0x41/0x42/0x44 as 0, ignore writes to them, and hold IS[11] at 0.

Verification
REQ-026 SHALL cover: CRMD=0x7 (PLV=3, IE=1); exception with pc=0x1C000100, ecode=0x9, addr=0x00000003 -> next cycle ERA=0x1C000100, BADV=0x3, PRMD=0x7, CRMD.PLV=0, CRMD.IE=0, ESTAT[21:16]=0x9.
REQ-027 SHALL cover: ertn issued after REQ-026 -> CRMD[2:0]=0x7, csr_era_o unchanged.
REQ-028 SHALL cover: write EENTRY=0xFFFFFFFF -> csr_eentry_o=0xFFFFFFC0; write to address 0x3 -> reads 0.
REQ-029 SHALL cover: LIE=0x004, CRMD.IE=1, hw_int_i=0x01 -> csr_is_interrupt_o=1 one cycle later; with IE=0 -> csr_is_interrupt_o=0.
REQ-030 SHALL cover (CSR_TIMER_EN): TCFG=0x0000000B (InitVal=2, periodic, En) -> TVAL 8,7,...,1,0; IS[11]=1 when TVAL reaches 0; TVAL reloads 8; TICLR=1 -> IS[11]=0.
REQ-031 SHALL cover: simultaneous exception and CSR write to CRMD=0x3 -> exception fields applied, CRMD.PLV=0; rst mid-countdown -> TVAL=0, CRMD=0x8.
